// File: rtl/rca_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rca_pkg
// Description : Shared widths and types for the three-operand ripple-carry
//               adder and its operand collector.
// Revision    : 1.0 - initial release
// ============================================================================
package rca_pkg;

  // Default operand width and the adder's result width (3 * 255 fits in 11 bits)
  localparam int OPW  = 8;
  localparam int SUMW = 11;

  // Slot index within the triple currently being gathered
  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2
  } slot_t;

  // Number of real operands carried by an emitted triple
  typedef logic [1:0] cnt_t;

  // Slot following the given one (only called below SLOT2)
  function automatic slot_t next_slot(input slot_t s);
    return slot_t'(2'(s) + 2'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rca_operand_collector.sv
`default_nettype none
// ============================================================================
// Module      : rca_operand_collector
// Description : Packs a valid/ready operand stream into registered (a, b, c)
//               triples for the three-operand ripple-carry adder. Partial
//               groups closed by in_last are zero-padded.
// Options     : RCA_OPCOLL_LAST_EN - honour in_last (partial flush, out_cnt
//               and out_last). Undefined: in_last ignored, full triples only.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_operand_collector
  import rca_pkg::*;
#(
  parameter int W = OPW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [1:0]   out_cnt,
  output logic         out_last
);

  slot_t          idx_q, idx_d;
  logic [W-1:0]   s0_q, s0_d;
  logic [W-1:0]   s1_q, s1_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   c_q, c_d;
  cnt_t           cnt_q, cnt_d;
  logic           last_q, last_d;
  logic           valid_q, valid_d;

  logic           w_accept;
  logic           w_last;
  logic           w_complete;

`ifdef RCA_OPCOLL_LAST_EN
  assign w_last = in_last;
`else
  // in_last is read but masked so the port stays present and inert
  assign w_last = in_last & 1'b0;
`endif

  // Upstream may advance whenever the output slot is free or being drained
  assign in_ready   = !valid_q || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_complete = w_accept && ((idx_q == SLOT2) || w_last);

  // Next-state for staging, slot index and output triple
  always_comb begin
    idx_d   = idx_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    valid_d = valid_q;

    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (w_accept) begin
      if (w_complete) begin
        // Slots not yet filled are padded with zero so the sum is unchanged
        a_d     = (idx_q == SLOT0) ? in_data : s0_q;
        b_d     = (idx_q == SLOT1) ? in_data :
                  (idx_q == SLOT2) ? s1_q    : '0;
        c_d     = (idx_q == SLOT2) ? in_data : '0;
        cnt_d   = cnt_t'(idx_q) + 2'd1;
        last_d  = w_last;
        valid_d = 1'b1;
        idx_d   = SLOT0;
        s0_d    = '0;
        s1_d    = '0;
      end else begin
        case (idx_q)
          SLOT0:   s0_d = in_data;
          SLOT1:   s1_d = in_data;
          default: ;
        endcase
        idx_d = next_slot(idx_q);
      end
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= SLOT0;
      s0_q    <= '0;
      s1_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign a         = a_q;
  assign b         = b_q;
  assign c         = c_q;
  assign out_cnt   = cnt_q;
  assign out_last  = last_q;

endmodule
`default_nettype wire

// File: tb/tb_rca_operand_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_rca_operand_collector
// Description : Directed self-checking bench for rca_operand_collector.
//               Scenario 4 follows RCA_OPCOLL_LAST_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_operand_collector;
  import rca_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_data;
  logic           in_last;
  logic           out_valid;
  logic           out_ready;
  logic [OPW-1:0] a, b, c;
  logic [1:0]     out_cnt;
  logic           out_last;
  logic [SUMW-1:0] sum;

  int tests = 0;
  int fails = 0;

  rca_operand_collector #(.W(OPW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_cnt   (out_cnt),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Model of the downstream adder consuming the triple
  assign sum = SUMW'(a) + SUMW'(b) + SUMW'(c);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_triple(input string tag, input logic [7:0] ea, eb, ec,
                              input logic [1:0] ecnt, input logic elast);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_a"},     32'(a),         32'(ea));
    check({tag, "_b"},     32'(b),         32'(eb));
    check({tag, "_c"},     32'(c),         32'(ec));
    check({tag, "_cnt"},   32'(out_cnt),   32'(ecnt));
    check({tag, "_last"},  32'(out_last),  32'(elast));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_a",     32'(a),         32'd0);
    check("rst_b",     32'(b),         32'd0);
    check("rst_c",     32'(c),         32'd0);
    check("rst_cnt",   32'(out_cnt),   32'd0);
    check("rst_last",  32'(out_last),  32'd0);
    check("rst_ready", 32'(in_ready),  32'd1);

    // 1: simple triple 1,2,3
    in_valid = 1'b1;
    in_data = 8'h01; tick();
    in_data = 8'h02; tick();
    in_data = 8'h03;
    check("s1_pre_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    check_triple("s1", 8'h01, 8'h02, 8'h03, 2'd3, 1'b0);
    check("s1_sum", 32'(sum), 32'd6);
    tick();
    check("s1_drain", 32'(out_valid), 32'd0);

    // 2: six 0xFF operands back-to-back
    in_valid = 1'b1; in_data = 8'hFF;
    for (int k = 1; k <= 6; k++) begin
      check($sformatf("s2_ready%0d", k), 32'(in_ready), 32'd1);
      tick();
      if (k == 3 || k == 6) begin
        check_triple($sformatf("s2_t%0d", k / 3), 8'hFF, 8'hFF, 8'hFF, 2'd3, 1'b0);
        check($sformatf("s2_sum%0d", k / 3), 32'(sum), 32'd765);
      end
      if (k == 4) check("s2_gap", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    tick();
    check("s2_drain", 32'(out_valid), 32'd0);

    // 3: backpressure on a completed triple
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h10; tick();
    in_data = 8'h20; tick();
    in_data = 8'h30; tick();
    in_data = 8'h40;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("s3_ready%0d", k), 32'(in_ready), 32'd0);
      check_triple($sformatf("s3_hold%0d", k), 8'h10, 8'h20, 8'h30, 2'd3, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("s3_release_ready", 32'(in_ready), 32'd1);
    tick();
    check("s3_handshake", 32'(out_valid), 32'd0);
    in_data = 8'h50; tick();
    in_data = 8'h60; tick();
    in_valid = 1'b0;
    check_triple("s3_next", 8'h40, 8'h50, 8'h60, 2'd3, 1'b0);
    tick();
    check("s3_drain", 32'(out_valid), 32'd0);

    // 4: in_last handling
    in_valid = 1'b1;
    in_data = 8'hAA; in_last = 1'b0; tick();
    in_data = 8'h55; in_last = 1'b1; tick();
`ifdef RCA_OPCOLL_LAST_EN
    check_triple("s4_flush2", 8'hAA, 8'h55, 8'h00, 2'd2, 1'b1);
    check("s4_sum2", 32'(sum), 32'h0FF);
    in_data = 8'h07; in_last = 1'b1; tick();
    // handshake and new completion on the same edge keep out_valid high
    check_triple("s4_flush1", 8'h07, 8'h00, 8'h00, 2'd1, 1'b1);
`else
    check("s4_noflush", 32'(out_valid), 32'd0);
    in_data = 8'h01; in_last = 1'b0; tick();
    check_triple("s4_full", 8'hAA, 8'h55, 8'h01, 2'd3, 1'b0);
`endif
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    check("s4_drain", 32'(out_valid), 32'd0);

    // 5: reset in the middle of a triple
    in_valid = 1'b1;
    in_data = 8'h99; tick();
    in_data = 8'h98; tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    check("s5_in_rst", 32'(out_valid), 32'd0);
    rst = 1'b0;
    tick();
    check("s5_after_rst", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_data = 8'h04; tick();
    check("s5_after4", 32'(out_valid), 32'd0);
    in_data = 8'h05; tick();
    check("s5_after5", 32'(out_valid), 32'd0);
    in_data = 8'h06; tick();
    in_valid = 1'b0;
    check_triple("s5", 8'h04, 8'h05, 8'h06, 2'd3, 1'b0);
    check("s5_sum", 32'(sum), 32'd15);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
